// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg: state encodings, opcode/op constants and writeback selects
// shared by the controller and its decoder.
package cpu_controller_pkg;
  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_e;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [3:0] VSEL_MDATA = 4'b0001;
  localparam logic [3:0] VSEL_IMM   = 4'b0010;
  localparam logic [3:0] VSEL_C     = 4'b1000;
endpackage

// File: rtl/cpu_controller_instruction_decoder.sv
// instruction_decoder: splits an instruction word into its fields and
// sign-extended immediates.
// Ports: ir_i instruction word; opcode_o/op_o/rn_o/rd_o/rm_o/sh_o fields;
//        sximm5_o/sximm8_o sign-extended IR[4:0]/IR[7:0].
module instruction_decoder (
  input  logic [15:0] ir_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  rm_o,
  output logic [15:0] sximm5_o,
  output logic [15:0] sximm8_o
);
  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register plus Moore FSM driving the 16-bit datapath.
// Ports: clk/reset (sync, active-high); in/load/s instruction word, IR capture, start;
//        w ready; readnum/writenum/write register file; vsel writeback select;
//        loada/loadb/asel/bsel/shift/ALUop/loadc/loads datapath controls;
//        sximm5/sximm8 sign-extended immediates.
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);
  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;
  logic [15:0] sx5, sx8;
  logic        mov_imm, mov_reg, mvn, cmp, alu3;
  // Outputs are registered from the next state, so the decoder looks at the
  // next IR value; this keeps them aligned with the IR the state will see.
  instruction_decoder u_dec (
    .ir_i(ir_d), .opcode_o(opcode), .op_o(op), .rn_o(rn), .rd_o(rd),
    .sh_o(sh), .rm_o(rm), .sximm5_o(sx5), .sximm8_o(sx8)
  );
  assign ir_d    = (state_q == S_WAIT && load) ? in : ir_q;
  assign mov_imm = opcode == OPC_MOV && op == OP_MOV_IMM;
  assign mov_reg = opcode == OPC_MOV && op == OP_MOV_REG;
  assign mvn     = opcode == OPC_ALU && op == OP_MVN;
  assign cmp     = opcode == OPC_ALU && op == OP_CMP;
  assign alu3    = opcode == OPC_ALU && op != OP_MVN;
  assign bsel    = 1'b0;
  always_comb begin
    state_d = S_WAIT;
    case (state_q)
      S_WAIT:   state_d = s ? S_DECODE : S_WAIT;
      S_DECODE: state_d = mov_imm ? S_WRITE_IMM : (mov_reg || mvn) ? S_GET_B : alu3 ? S_GET_A : S_WAIT;
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_ALU;
      S_ALU:    state_d = cmp ? S_WAIT : S_WRITE_REG;
      default:  state_d = S_WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_WAIT;
      ir_q     <= '0;
      w        <= 1'b1;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      vsel     <= VSEL_MDATA;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      asel     <= 1'b0;
      shift    <= '0;
      ALUop    <= '0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      sximm5   <= '0;
      sximm8   <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      w        <= state_d == S_WAIT;
      readnum  <= state_d == S_GET_B ? rm : rn;
      writenum <= state_d == S_WRITE_REG ? rd : rn;
      write    <= state_d == S_WRITE_IMM || state_d == S_WRITE_REG;
      vsel     <= state_d == S_WRITE_IMM ? VSEL_IMM : state_d == S_WRITE_REG ? VSEL_C : VSEL_MDATA;
      loada    <= state_d == S_GET_A;
      loadb    <= state_d == S_GET_B;
      asel     <= state_d == S_ALU && (mov_reg || mvn);
      shift    <= sh;
      // MOV reg has op 00 (add) and MVN has op 11 (not-B), so op is the ALU op throughout.
      ALUop    <= op;
      loadc    <= state_d == S_ALU && !cmp;
      loads    <= state_d == S_ALU && cmp;
      sximm5   <= sx5;
      sximm8   <= sx8;
    end
  end
endmodule
